// File: rtl/keypad_lock_pkg.sv
// Shared constants for the keypad lock: default geometry, factory code and FSM encoding.
package keypad_lock_pkg;

    localparam int unsigned DefaultDigits = 4;
    localparam int unsigned DefaultDigitW = 4;
    localparam logic [15:0] DefaultCode   = 16'h2468;

    typedef logic [2:0] state_t;

    localparam state_t StEntry   = 3'd0;
    localparam state_t StCheck   = 3'd1;
    localparam state_t StOpen    = 3'd2;
    localparam state_t StProgram = 3'd3;
    localparam state_t StLockout = 3'd4;

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad-side handshake between the scan/debounce front end (master) and the lock FSM (slave).
interface keypad_lock_ctrl_if #(
    parameter int unsigned DIGIT_W = 4
);
    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               key_clear;
    logic               prog_req;
    logic               key_ready;

    modport master (
        output key_valid, key_digit, key_clear, prog_req,
        input  key_ready
    );

    modport slave (
        input  key_valid, key_digit, key_clear, prog_req,
        output key_ready
    );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
module lock_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock FSM: code entry, compare, unlock window, lockout after repeated failures, reprogramming.
module keypad_lock_ctrl
    import keypad_lock_pkg::*;
#(
    parameter int unsigned                   DIGITS       = DefaultDigits,
    parameter int unsigned                   DIGIT_W      = DefaultDigitW,
    parameter logic [DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = DefaultCode,
    parameter int unsigned                   MAX_FAIL     = 3,
    parameter int unsigned                   LOCKOUT_CYC  = 16,
    parameter int unsigned                   UNLOCK_CYC   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    keypad_lock_ctrl_if.slave            kif,
    output logic                         unlock,
    output logic                         error,
    output logic                         locked_out,
    output logic                         prog_mode,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count
);

    localparam int unsigned CodeW  = DIGITS * DIGIT_W;
    localparam int unsigned CntW   = $clog2(DIGITS + 1);
    localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);
    localparam int unsigned MaxCyc = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int unsigned TimerW = $clog2(MaxCyc + 1);

    state_t             state_q, state_d;
    logic [CodeW-1:0]   code_q, code_d;
    logic [CodeW-1:0]   buf_q, buf_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [FailW-1:0]   fail_q, fail_d;
    logic               unlock_q, unlock_d;
    logic               error_q, error_d;
    logic               locked_q, locked_d;
    logic               prog_q, prog_d;

    logic               key_ready;
    logic               key_accept;
    logic               last_digit;
    logic [CodeW-1:0]   buf_shift;
    logic               unlock_load, unlock_done;
    logic               lock_load, lock_done;

    assign key_ready     = (state_q == StEntry) || (state_q == StProgram);
    assign kif.key_ready = key_ready;
    assign key_accept    = kif.key_valid && key_ready && !kif.key_clear;
    assign last_digit    = (cnt_q == CntW'(DIGITS - 1));
    // First digit entered ends up in the MSBs.
    assign buf_shift     = {buf_q[CodeW-DIGIT_W-1:0], kif.key_digit};

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        error_d     = 1'b0;
        unlock_load = 1'b0;
        lock_load   = 1'b0;
        case (state_q)
            StEntry, StProgram: begin
                if (kif.key_clear) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (key_accept) begin
                    if (!last_digit) begin
                        buf_d = buf_shift;
                        cnt_d = cnt_q + CntW'(1);
                    end else if (state_q == StEntry) begin
                        buf_d   = buf_shift;
                        cnt_d   = CntW'(DIGITS);
                        state_d = StCheck;
                        // Pre-compute so error is a registered pulse during CHECK.
                        error_d = (buf_shift != code_q);
                    end else begin
                        code_d  = buf_shift;
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = StEntry;
                    end
                end
            end
            StCheck: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == code_q) begin
                    fail_d      = '0;
                    state_d     = StOpen;
                    unlock_load = 1'b1;
                end else begin
                    fail_d = fail_q + FailW'(1);
                    if (fail_q == FailW'(MAX_FAIL - 1)) begin
                        state_d   = StLockout;
                        lock_load = 1'b1;
                    end else begin
                        state_d = StEntry;
                    end
                end
            end
            StOpen: begin
                if (kif.prog_req) begin
                    state_d = StProgram;
                end else if (unlock_done) begin
                    state_d = StEntry;
                end
            end
            StLockout: begin
                if (lock_done) begin
                    state_d = StEntry;
                    fail_d  = '0;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    assign unlock_d = (state_d == StOpen);
    assign locked_d = (state_d == StLockout);
    assign prog_d   = (state_d == StProgram);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StEntry;
            code_q   <= DEFAULT_CODE;
            buf_q    <= '0;
            cnt_q    <= '0;
            fail_q   <= '0;
            unlock_q <= 1'b0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
            prog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            unlock_q <= unlock_d;
            error_q  <= error_d;
            locked_q <= locked_d;
            prog_q   <= prog_d;
        end
    end

    // Timers count LOAD-1 down to 0 so the window spans exactly LOAD cycles.
    lock_timer #(
        .Width (TimerW)
    ) u_unlock_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (unlock_load),
        .load_val (TimerW'(UNLOCK_CYC - 1)),
        .done     (unlock_done)
    );

    lock_timer #(
        .Width (TimerW)
    ) u_lockout_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (lock_load),
        .load_val (TimerW'(LOCKOUT_CYC - 1)),
        .done     (lock_done)
    );

    assign unlock      = unlock_q;
    assign error       = error_q;
    assign locked_out  = locked_q;
    assign prog_mode   = prog_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl: entry, lockout, clear, reprogramming and reset recovery.
module tb_keypad_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       unlock;
    logic       error;
    logic       locked_out;
    logic       prog_mode;
    logic [2:0] digit_count;

    int checks   = 0;
    int failures = 0;

    keypad_lock_ctrl_if #(.DIGIT_W(4)) kif ();

    keypad_lock_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .kif         (kif.slave),
        .unlock      (unlock),
        .error       (error),
        .locked_out  (locked_out),
        .prog_mode   (prog_mode),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        kif.key_valid = 1'b1;
        kif.key_digit = d;
        tick();
        kif.key_valid = 1'b0;
    endtask

    // Leaves the DUT in its CHECK cycle.
    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            press(code[15-4*i -: 4]);
        end
    endtask

    // Called on OPEN cycle 1; runs out the remaining window.
    task automatic wait_open();
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("open_hold", unlock, 1);
            chk("open_no_err", error, 0);
        end
        tick();
        chk("open_end", unlock, 0);
        chk("open_end_ready", kif.key_ready, 1);
    endtask

    task automatic try_code(input logic [15:0] code, input logic exp_err, input string tag);
        enter_code(code);
        chk({tag, "_check_ready"}, kif.key_ready, 0);
        chk({tag, "_err"}, error, exp_err);
        tick();
        chk({tag, "_err_gone"}, error, 0);
        chk({tag, "_unlock"}, unlock, !exp_err);
    endtask

    initial begin
        reset         = 1'b1;
        kif.key_valid = 1'b0;
        kif.key_digit = '0;
        kif.key_clear = 1'b0;
        kif.prog_req  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_unlock", unlock, 0);
        chk("rst_error", error, 0);
        chk("rst_locked", locked_out, 0);
        chk("rst_prog", prog_mode, 0);
        chk("rst_ready", kif.key_ready, 1);
        chk("rst_count", digit_count, 0);

        // 1: default code opens for exactly 8 cycles
        press(4'd2);
        chk("t1_cnt1", digit_count, 1);
        press(4'd4);
        press(4'd6);
        chk("t1_cnt3", digit_count, 3);
        press(4'd8);
        chk("t1_check_cnt", digit_count, 4);
        chk("t1_check_err", error, 0);
        chk("t1_check_ready", kif.key_ready, 0);
        chk("t1_check_unlock", unlock, 0);
        tick();
        chk("t1_open1", unlock, 1);
        chk("t1_open_cnt", digit_count, 0);
        wait_open();

        // 2: three failures lock out for 16 cycles
        try_code(16'h1111, 1'b1, "t2_w1");
        chk("t2_w1_locked", locked_out, 0);
        try_code(16'h1111, 1'b1, "t2_w2");
        chk("t2_w2_locked", locked_out, 0);
        try_code(16'h1111, 1'b1, "t2_w3");
        chk("t2_lock1", locked_out, 1);
        chk("t2_lock_ready", kif.key_ready, 0);
        kif.key_valid = 1'b1;
        kif.key_digit = 4'd2;
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("t2_lock_hold", locked_out, 1);
            chk("t2_lock_cnt", digit_count, 0);
            if (i == 4) kif.key_valid = 1'b0;
        end
        kif.key_valid = 1'b0;
        tick();
        chk("t2_lock_end", locked_out, 0);
        chk("t2_lock_end_ready", kif.key_ready, 1);
        try_code(16'h2468, 1'b0, "t2_good");
        wait_open();

        // 3: clear wins over a digit and does not touch the failure count
        try_code(16'h1357, 1'b1, "t3_w1");
        try_code(16'h1357, 1'b1, "t3_w2");
        press(4'd2);
        press(4'd4);
        chk("t3_pre_clear", digit_count, 2);
        kif.key_valid = 1'b1;
        kif.key_digit = 4'd6;
        kif.key_clear = 1'b1;
        tick();
        kif.key_valid = 1'b0;
        kif.key_clear = 1'b0;
        chk("t3_cleared", digit_count, 0);
        try_code(16'h2468, 1'b0, "t3_good");
        chk("t3_no_lock", locked_out, 0);
        wait_open();

        // 4: reprogram from OPEN cycle 3
        try_code(16'h2468, 1'b0, "t4_open");
        tick();
        tick();
        chk("t4_open3", unlock, 1);
        kif.prog_req = 1'b1;
        tick();
        kif.prog_req = 1'b0;
        chk("t4_prog_unlock", unlock, 0);
        chk("t4_prog_mode", prog_mode, 1);
        chk("t4_prog_ready", kif.key_ready, 1);
        enter_code(16'h9307);
        chk("t4_prog_done", prog_mode, 0);
        chk("t4_prog_cnt", digit_count, 0);
        chk("t4_prog_noerr", error, 0);
        try_code(16'h2468, 1'b1, "t4_old");
        try_code(16'h9307, 1'b0, "t4_new");
        wait_open();

        // 5: reset restores the factory code
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_unlock", unlock, 0);
        chk("t5_prog", prog_mode, 0);
        chk("t5_locked", locked_out, 0);
        chk("t5_ready", kif.key_ready, 1);
        try_code(16'h9307, 1'b1, "t5_old");
        try_code(16'h2468, 1'b0, "t5_good");
        wait_open();

        // 6: a match clears the failure count
        try_code(16'h0000, 1'b1, "t6_w1");
        try_code(16'h0001, 1'b1, "t6_w2");
        try_code(16'h2468, 1'b0, "t6_good");
        wait_open();
        try_code(16'h0002, 1'b1, "t6_w3");
        chk("t6_w3_locked", locked_out, 0);
        try_code(16'h0003, 1'b1, "t6_w4");
        chk("t6_w4_locked", locked_out, 0);
        chk("t6_w4_ready", kif.key_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
